// File: rtl/arb_rr_n_pkg.sv
// Shared arbiter definitions: FSM state codes, ID width helper and the
// slave mode encodings carried through slvx_mode.
package arb_pkg;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t XFER = 1'b1;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_PROC   = 2'd1;
  localparam logic [1:0] MODE_CFG    = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_rr_n_if.sv
// Slave-side request bus plus registered output beat of the N-way arbiter.
interface arb_rr_n_if #(
  parameter int NUM_SLV = 4,
  parameter int DW      = 32,
  parameter int MODE_W  = 2,
  parameter int PROC_W  = 8
);
  localparam int ID_W = arb_pkg::id_w(NUM_SLV);

  logic                       mstr_cmplt;
  logic                       fifo_full;
  logic [NUM_SLV*MODE_W-1:0]  slv_mode;
  logic [NUM_SLV-1:0]         slv_data_valid;
  logic [NUM_SLV*PROC_W-1:0]  slv_proc_valid;
  logic [NUM_SLV*DW-1:0]      slv_data;
  logic [NUM_SLV-1:0]         slv_ready;
  logic [MODE_W-1:0]          slvx_mode;
  logic                       slvx_data_valid;
  logic [PROC_W-1:0]          slvx_proc_val;
  logic [DW-1:0]              slvx_data;
  logic [ID_W-1:0]            slvx_id;

  modport master (
    input  mstr_cmplt, fifo_full, slv_mode, slv_data_valid, slv_proc_valid, slv_data,
    output slv_ready, slvx_mode, slvx_data_valid, slvx_proc_val, slvx_data, slvx_id
  );

  modport slave (
    output mstr_cmplt, fifo_full, slv_mode, slv_data_valid, slv_proc_valid, slv_data,
    input  slv_ready, slvx_mode, slvx_data_valid, slvx_proc_val, slvx_data, slvx_id
  );

endinterface

// File: rtl/arb_rr_n_rr_picker.sv
// Combinational rotate-priority picker: first set request at or above base,
// wrapping; base is forced to 0 for fixed (lowest index wins) priority.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          fixed,
  output logic [IW-1:0] win,
  output logic          any_req
);
  logic [IW-1:0]  base;
  logic [2*N-1:0] dbl;
  int             off;
  int             sum;

  assign any_req = |req;

  // Doubling the vector turns the wrap-around scan into a plain shift.
  always_comb begin
    base = fixed ? '0 : ptr;
    dbl  = {req, req} >> base;
    off  = 0;
    for (int k = N - 1; k >= 0; k--)
      if (dbl[k]) off = k;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    win = IW'(sum);
  end

endmodule

// File: rtl/arb_rr_n.sv
// N-slave arbiter with packet-level grant lock, burst limit, FIFO
// backpressure and a one-cycle registered output stage tagged with source ID.
module arb_rr_n import arb_pkg::*; #(
  parameter int NUM_SLV   = 4,
  parameter int DW        = 32,
  parameter int MODE_W    = 2,
  parameter int PROC_W    = 8,
  parameter int MAX_BEATS = 256,
  parameter int ARB_FIXED = 0
) (
  input  logic       clk,
  input  logic       rst,
  arb_rr_n_if.master bus
);
  localparam int ID_W  = id_w(NUM_SLV);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  state_t           state;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  win;
  logic [CNT_W-1:0] beat_cnt;
  logic             any_req;
  logic             xfer_ok;
  logic             beat;
  logic             rel;

  rr_picker #(.N(NUM_SLV), .IW(ID_W)) u_pick (
    .req     (bus.slv_data_valid),
    .ptr     (ptr),
    .fixed   (ARB_FIXED != 0),
    .win     (win),
    .any_req (any_req)
  );

  // mstr_cmplt suppresses ready so a release cycle never also accepts a beat.
  assign xfer_ok = !rst && (state == XFER) && !bus.fifo_full && !bus.mstr_cmplt;
  assign beat    = xfer_ok && bus.slv_data_valid[gnt_id];
  assign rel     = (state == XFER) &&
                   (bus.mstr_cmplt || (beat && beat_cnt == CNT_W'(MAX_BEATS - 1)));

  always_comb begin
    bus.slv_ready = '0;
    if (xfer_ok) bus.slv_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      ptr                 <= '0;
      gnt_id              <= '0;
      beat_cnt            <= '0;
      bus.slvx_mode       <= '0;
      bus.slvx_data_valid <= 1'b0;
      bus.slvx_proc_val   <= '0;
      bus.slvx_data       <= '0;
      bus.slvx_id         <= '0;
    end else begin
      if (state == IDLE) begin
        if (any_req) begin
          state         <= XFER;
          gnt_id        <= win;
          beat_cnt      <= '0;
          bus.slvx_mode <= bus.slv_mode[win*MODE_W +: MODE_W];
        end
      end else begin
        if (beat) beat_cnt <= beat_cnt + 1'b1;
        if (rel) begin
          state <= IDLE;
          ptr   <= (gnt_id == ID_W'(NUM_SLV - 1)) ? '0 : gnt_id + 1'b1;
        end
      end

      bus.slvx_data_valid <= beat;
      if (beat) begin
        bus.slvx_data     <= bus.slv_data[gnt_id*DW +: DW];
        bus.slvx_proc_val <= bus.slv_proc_valid[gnt_id*PROC_W +: PROC_W];
        bus.slvx_id       <= gnt_id;
      end
    end
  end

endmodule
